// File: rtl/demodulate_pi_div2.sv
// rtl/demodulate_pi_div2.sv - fs/4 down-shift: rotates each accepted sample by (-j)^k, with output and skid registers.
// Optional saturating negation of the most negative value when DEMOD_PI_DIV2_SAT_EN is defined.
module demodulate_pi_div2 #(
    parameter int G_DWIDTH = 24
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [1:0]          phase_init_i,
    input  logic [G_DWIDTH-1:0] din_re_i,
    input  logic [G_DWIDTH-1:0] din_im_i,
    input  logic                din_valid_i,
    output logic                din_ready_o,
    output logic [G_DWIDTH-1:0] dout_re_o,
    output logic [G_DWIDTH-1:0] dout_im_o,
    output logic                dout_valid_o,
    input  logic                dout_ready_i,
    output logic [1:0]          phase_o
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [G_DWIDTH-1:0] o_re_q, o_re_d, o_im_q, o_im_d;
    logic [G_DWIDTH-1:0] s_re_q, s_re_d, s_im_q, s_im_d;
    logic                o_valid_q, o_valid_d;
    logic                s_full_q, s_full_d;
    logic                rdy_q, rdy_d;
    logic [G_DWIDTH-1:0] rot_re, rot_im;
    logic                in_acc, out_acc;

    function automatic logic [G_DWIDTH-1:0] neg(input logic [G_DWIDTH-1:0] x);
`ifdef DEMOD_PI_DIV2_SAT_EN
        if (x == {1'b1, {(G_DWIDTH-1){1'b0}}})
            return {1'b0, {(G_DWIDTH-1){1'b1}}};
        else
            return -x;
`else
        return -x;
`endif
    endfunction

    always_comb begin
        rot_re = din_re_i;
        rot_im = din_im_i;
        case (phase_q)
            2'd1: begin rot_re = din_im_i;      rot_im = neg(din_re_i); end
            2'd2: begin rot_re = neg(din_re_i); rot_im = neg(din_im_i); end
            2'd3: begin rot_re = neg(din_im_i); rot_im = din_re_i;      end
            default: ;
        endcase
    end

    assign in_acc  = din_valid_i & rdy_q;
    assign out_acc = o_valid_q & dout_ready_i;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        o_re_d    = o_re_q;
        o_im_d    = o_im_q;
        s_re_d    = s_re_q;
        s_im_d    = s_im_q;
        o_valid_d = o_valid_q;
        s_full_d  = s_full_q;
        rdy_d     = rdy_q;
        if (state_q == ST_INIT) begin
            state_d = ST_RUN;
            rdy_d   = 1'b1;
        end else begin
            if (in_acc)
                phase_d = phase_q + 2'd1;
            // O is free this cycle: skid content has priority, since rdy_q=0 whenever S is full
            if (!o_valid_q || out_acc) begin
                if (s_full_q) begin
                    o_re_d    = s_re_q;
                    o_im_d    = s_im_q;
                    o_valid_d = 1'b1;
                    s_full_d  = 1'b0;
                end else if (in_acc) begin
                    o_re_d    = rot_re;
                    o_im_d    = rot_im;
                    o_valid_d = 1'b1;
                end else begin
                    o_valid_d = 1'b0;
                end
            end else if (in_acc) begin
                s_re_d   = rot_re;
                s_im_d   = rot_im;
                s_full_d = 1'b1;
            end
            rdy_d = !s_full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i) begin
            state_q   <= ST_INIT;
            phase_q   <= phase_init_i;
            o_re_q    <= '0;
            o_im_q    <= '0;
            s_re_q    <= '0;
            s_im_q    <= '0;
            o_valid_q <= 1'b0;
            s_full_q  <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            o_re_q    <= o_re_d;
            o_im_q    <= o_im_d;
            s_re_q    <= s_re_d;
            s_im_q    <= s_im_d;
            o_valid_q <= o_valid_d;
            s_full_q  <= s_full_d;
            rdy_q     <= rdy_d;
        end
    end

    assign din_ready_o  = rdy_q;
    assign dout_re_o    = o_re_q;
    assign dout_im_o    = o_im_q;
    assign dout_valid_o = o_valid_q;
    assign phase_o      = phase_q;

endmodule
